tag_sysid_checker: RTL and testbench

- Avalon-MM master that reads the system-ID peripheral's control slave (word 0 = ID, word 1 = build timestamp) and compares both words against expected values.
- Sits between the HPS/Nios reset domain and the status LEDs or PIO, so a mismatched FPGA image is flagged in hardware before software runs.
- Runs automatically once after reset; can be re-triggered by a start pulse.

---
 rtl/tag_sysid_pkg.sv | 32 +++
 rtl/tag_sysid_stall_timer.sv | 46 ++++
 rtl/tag_sysid_checker.sv | 201 ++++++++++++++++++++
 tb/tb_tag_sysid_checker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_sysid_pkg.sv
// ============================================================================
// Module      : tag_sysid_pkg
// Description : Shared types and constants for the system-ID image checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tag_sysid_pkg;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        IDLE    = 3'd1,
        RD_ID   = 3'd2,
        RD_TS   = 3'd3,
        BACKOFF = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    localparam logic     SYSID_ADDR_ID  = 1'b0;
    localparam logic     SYSID_ADDR_TS  = 1'b1;
    localparam int       STALL_CNT_W    = 16;
    localparam int       BACKOFF_CYCLES = 16;
    localparam logic [1:0] MAX_RETRIES  = 2'd3;

    function automatic logic is_busy(input state_t s);
        return (s inside {BOOT, RD_ID, RD_TS, BACKOFF});
    endfunction

endpackage

`default_nettype wire

// File: rtl/tag_sysid_stall_timer.sv
// ============================================================================
// Module      : tag_sysid_stall_timer
// Description : Clearable up-counter; expired flags the last cycle of a limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_sysid_stall_timer
    import tag_sysid_pkg::*;
#(
    parameter int W = STALL_CNT_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Expired during the limit-th enabled cycle, so the caller acts on that edge.
    assign expired = (count_q == (limit - {{(W-1){1'b0}}, 1'b1}));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tag_sysid_checker.sv
// ============================================================================
// Module      : tag_sysid_checker
// Description : Avalon-MM reader that checks sysid ID/timestamp after reset.
//               Optional retry/backoff enabled by SYSID_CHECK_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_sysid_checker
    import tag_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h606F_FD69,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
`ifdef SYSID_CHECK_RETRY_EN
    output logic [1:0]  retry_cnt,
`endif
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [STALL_CNT_W-1:0] TO_LIMIT = STALL_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [STALL_CNT_W-1:0] BO_LIMIT = STALL_CNT_W'(BACKOFF_CYCLES);

    state_t      state_q, state_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] captured_id_q, captured_id_d;
    logic [31:0] captured_ts_q, captured_ts_d;

    logic                   accept, stalled, abort, can_retry;
    logic                   timer_clr, timer_en, timer_expired;
    logic [STALL_CNT_W-1:0] timer_limit;

    tag_sysid_stall_timer #(.W(STALL_CNT_W)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .limit   (timer_limit),
        .expired (timer_expired)
    );

`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0] retry_q, retry_d;

    assign can_retry = (retry_q != MAX_RETRIES);
    assign retry_cnt = retry_q;

    always_comb begin
        retry_d = retry_q;
        if ((state_q == BOOT) ||
            (start && (state_q inside {IDLE, DONE, ERR}))) begin
            retry_d = 2'd0;
        end else if ((state_d == BACKOFF) && (state_q != BACKOFF)) begin
            retry_d = retry_q + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign can_retry = 1'b0;
`endif

    assign accept    = avm_read_q & ~avm_waitrequest;
    assign stalled   = avm_read_q &  avm_waitrequest;
    assign abort     = stalled & timer_expired;
    assign timer_clr = (state_d != state_q);

    always_comb begin
        state_d       = state_q;
        captured_id_d = captured_id_q;
        captured_ts_d = captured_ts_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        timer_en      = stalled;
        timer_limit   = TO_LIMIT;

        case (state_q)
            BOOT: state_d = RD_ID;
            IDLE, DONE, ERR: begin
                if (start) state_d = RD_ID;
            end
            RD_ID: begin
                if (accept) begin
                    captured_id_d = avm_readdata;
                    id_ok_d       = (avm_readdata == EXPECTED_ID);
                    state_d       = RD_TS;
                end else if (abort) begin
                    state_d = can_retry ? BACKOFF : ERR;
                end
            end
            RD_TS: begin
                if (accept) begin
                    captured_ts_d = avm_readdata;
                    ts_ok_d       = (avm_readdata == EXPECTED_TS);
                    if (id_ok_q && ts_ok_d) state_d = DONE;
                    else                    state_d = can_retry ? BACKOFF : DONE;
                end else if (abort) begin
                    state_d = can_retry ? BACKOFF : ERR;
                end
            end
            BACKOFF: begin
                timer_en    = 1'b1;
                timer_limit = BO_LIMIT;
                if (timer_expired) state_d = RD_ID;
            end
            default: state_d = BOOT;
        endcase

        // Every fresh attempt starts from a clean result set.
        if ((state_d == RD_ID) && (state_q != RD_ID)) begin
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end
        if ((state_d == DONE) && (state_q != DONE)) begin
            pass_d = id_ok_d & ts_ok_d;
        end
        if ((state_d == ERR) && (state_q != ERR)) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
        end

        avm_read_d    = (state_d inside {RD_ID, RD_TS});
        avm_address_d = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d        = is_busy(state_d);
        done_d        = (state_d inside {DONE, ERR});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BOOT;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            captured_id_q <= 32'd0;
            captured_ts_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            captured_id_q <= captured_id_d;
            captured_ts_q <= captured_ts_d;
        end
    end

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = captured_id_q;
    assign captured_ts = captured_ts_q;

endmodule

`default_nettype wire

// File: tb/tb_tag_sysid_checker.sv
// ============================================================================
// Module      : tb_tag_sysid_checker
// Description : Self-checking bench for tag_sysid_checker with a stalling slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tag_sysid_checker;

    localparam int TO = 8;
    localparam logic [31:0] GOOD_TS = 32'h606F_FD69;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;
`ifdef SYSID_CHECK_RETRY_EN
    logic [1:0]  retry_cnt;
`endif

    always #5 clock = ~clock;

    tag_sysid_checker #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (GOOD_TS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
`ifdef SYSID_CHECK_RETRY_EN
        .retry_cnt       (retry_cnt),
`endif
        .captured_id     (captured_id),
        .captured_ts     (captured_ts)
    );

    // Slave model: stalls s_stall_* cycles per read, can return a bad word 1.
    logic [31:0] s_w0 = 32'h0, s_w1 = GOOD_TS, s_w1_bad = 32'h606F_FD6A;
    int          s_stall_id = 0, s_stall_ts = 0, s_bad_ts = 0;
    int          s_cnt = 0, s_ts_reads = 0;

    always_comb begin
        avm_waitrequest = avm_read && (s_cnt < (avm_address ? s_stall_ts : s_stall_id));
        avm_readdata    = avm_address ? ((s_ts_reads < s_bad_ts) ? s_w1_bad : s_w1) : s_w0;
    end

    always @(posedge clock) begin
        if (avm_read && avm_waitrequest) s_cnt <= s_cnt + 1;
        else                             s_cnt <= 0;
        if (avm_read && !avm_waitrequest && avm_address) s_ts_reads <= s_ts_reads + 1;
    end

    typedef struct {
        int          lat, rds, idle;
        logic        id_ok, ts_ok, pass, to;
        logic [31:0] cid, cts;
        logic [1:0]  rc;
    } exp_t;

    typedef struct {
        logic [31:0] w0, w1;
        int          stall;
        bit          to, id_ok, ts_ok;
    } vec_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_cid = 0, m_cts = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic [31:0] w0, input logic [31:0] w1,
                                      input int stall, input bit to,
                                      input bit iok, input bit tok);
        exp_t e;
        int   attempt;
        bit   fail;
        fail    = to || !(iok && tok);
        attempt = to ? TO : 2 * (stall + 1);
        e.lat = 1 + attempt; e.rds = attempt; e.idle = 0; e.rc = 2'd0;
`ifdef SYSID_CHECK_RETRY_EN
        if (fail) begin
            e.lat  = 1 + 4 * attempt + 3 * 16;
            e.rds  = 4 * attempt;
            e.idle = 3 * 16;
            e.rc   = 2'd3;
        end
`endif
        e.id_ok = iok; e.ts_ok = tok; e.pass = !fail; e.to = to;
        if (!to) begin
            m_cid = w0;
            m_cts = w1;
        end
        e.cid = m_cid; e.cts = m_cts;
        return e;
    endfunction

    // Entered at a negedge; runs until done rises and scores against the queue head.
    task automatic run_one(input string nm, input bit pulse, input bit extra);
        int   lat = -1, rds = 0, idle = 0;
        exp_t e;
        if (pulse) start = 1'b1;
        for (int cyc = 1; cyc <= 500; cyc++) begin
            @(negedge clock);
            start = extra && (cyc == 1 || cyc == 2);
            if (avm_read) rds++;
            else if (busy) idle++;
            if (done) begin
                lat = cyc;
                break;
            end
        end
        start = 1'b0;
        if (sb.size() == 0) begin
            chk({nm, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({nm, ".lat"},     lat,         e.lat);
        chk({nm, ".reads"},   rds,         e.rds);
        chk({nm, ".idle"},    idle,        e.idle);
        chk({nm, ".busy"},    32'(busy),   32'd0);
        chk({nm, ".pass"},    32'(pass),   32'(e.pass));
        chk({nm, ".id_ok"},   32'(id_ok),  32'(e.id_ok));
        chk({nm, ".ts_ok"},   32'(ts_ok),  32'(e.ts_ok));
        chk({nm, ".timeout"}, 32'(timeout), 32'(e.to));
        chk({nm, ".cid"},     captured_id, e.cid);
        chk({nm, ".cts"},     captured_ts, e.cts);
`ifdef SYSID_CHECK_RETRY_EN
        chk({nm, ".retry"},   32'(retry_cnt), 32'(e.rc));
`endif
    endtask

    task automatic quiet_check(input string nm);
        int reads = 0, not_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (avm_read) reads++;
            if (!done) not_done++;
        end
        chk({nm, ".no_rerun"}, reads, 0);
        chk({nm, ".done_held"}, not_done, 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0,         GOOD_TS,        0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{32'h0,         32'h606F_FD6A,  0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h1,         GOOD_TS,        0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h0,         GOOD_TS,        5, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'hDEAD_BEEF, 32'h0,          2, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0,         GOOD_TS,   TO - 1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{32'h0,         GOOD_TS,       TO, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h0,         GOOD_TS,        0, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{32'hFFFF_FFFF, 32'h606F_FD68,  1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst.avm_read", 32'(avm_read), 32'd0);
        chk("rst.busy",     32'(busy),     32'd0);
        chk("rst.done",     32'(done),     32'd0);
        chk("rst.pass",     32'(pass),     32'd0);
        chk("rst.timeout",  32'(timeout),  32'd0);
        chk("rst.cid",      captured_id,   32'd0);
        chk("rst.cts",      captured_ts,   32'd0);

        // Auto-start after reset; a start coincident with release is dropped.
        reset_n = 1'b1;
        sb.push_back(make_exp(s_w0, s_w1, 0, 1'b0, 1'b1, 1'b1));
        run_one("boot", 1'b1, 1'b0);
        quiet_check("boot");

        foreach (vecs[i]) begin
            s_w0 = vecs[i].w0;
            s_w1 = vecs[i].w1;
            s_stall_id = vecs[i].stall;
            s_stall_ts = vecs[i].stall;
            sb.push_back(make_exp(vecs[i].w0, vecs[i].w1, vecs[i].stall,
                                  vecs[i].to, vecs[i].id_ok, vecs[i].ts_ok));
            run_one($sformatf("vec%0d", i), 1'b1, 1'b0);
        end

        // Start pulses while busy must not queue a second run.
        s_w0 = 32'h0; s_w1 = GOOD_TS; s_stall_id = 0; s_stall_ts = 0;
        sb.push_back(make_exp(s_w0, s_w1, 0, 1'b0, 1'b1, 1'b1));
        run_one("busy_start", 1'b1, 1'b1);
        quiet_check("busy_start");

        // Reset while RD_TS is stalled.
        s_stall_ts = 1000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("midrst.pre_id_ok", 32'(id_ok), 32'd1);
        chk("midrst.pre_addr",  32'(avm_address), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst.avm_read", 32'(avm_read), 32'd0);
        chk("midrst.id_ok",    32'(id_ok),    32'd0);
        chk("midrst.busy",     32'(busy),     32'd0);
        chk("midrst.done",     32'(done),     32'd0);
        s_stall_ts = 0;
        m_cid = 0; m_cts = 0;
        @(negedge clock);
        reset_n = 1'b1;
        sb.push_back(make_exp(s_w0, s_w1, 0, 1'b0, 1'b1, 1'b1));
        run_one("after_rst", 1'b0, 1'b0);

`ifdef SYSID_CHECK_RETRY_EN
        // Two bad timestamp reads, then a good one.
        begin
            exp_t e;
            s_bad_ts = s_ts_reads + 2;
            e = make_exp(s_w0, s_w1, 0, 1'b0, 1'b1, 1'b1);
            e.lat = 1 + 3 * 2 + 2 * 16; e.rds = 6; e.idle = 32; e.rc = 2'd2;
            sb.push_back(e);
            run_one("retry", 1'b1, 1'b0);
        end
`endif

        chk("sb.drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
